// File: rtl/game_flow_ctrl.sv
//==============================================================================
// Module   : game_flow_ctrl
// Purpose  : Game-flow controller for the ball/paddle game. Converts raw
//            collision/button levels into single-cycle strobes for the
//            statistics stage and sequences IDLE -> SERVE -> PLAY -> LOST ->
//            (SERVE | OVER) on frame ticks (vsync rising edges).
// Ports    : clk, reset (sync, active-high)
//            vsync, start_btn, brick_hit, ball_missed : input levels
//            lives_in[3:0]                            : lives from stats stage
//            incscore, declives, stats_reset          : 1-cycle strobes
//            ball_freeze, game_over, demo             : state-derived levels
//            state[2:0]                               : debug state encoding
// Options  : `define ATTRACT_MODE_EN enables the idle attract/demo state.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module game_flow_ctrl #(
  parameter int unsigned SERVE_FRAMES   = 60,
  parameter int unsigned LOST_FRAMES    = 90,
  parameter int unsigned ATTRACT_FRAMES = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start_btn,
  input  logic       brick_hit,
  input  logic       ball_missed,
  input  logic [3:0] lives_in,
  output logic       incscore,
  output logic       declives,
  output logic       stats_reset,
  output logic       ball_freeze,
  output logic       game_over,
  output logic       demo,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SERVE   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_LOST    = 3'd3,
    ST_OVER    = 3'd4,
    ST_ATTRACT = 3'd5
  } state_t;

  localparam logic [9:0] c_serve_frames = SERVE_FRAMES[9:0];
  localparam logic [9:0] c_lost_frames  = LOST_FRAMES[9:0];

  state_t     r_state;
  state_t     w_next;
  logic [9:0] r_cnt;
  logic       r_vsync_q, r_start_q, r_hit_q, r_miss_q;
  logic       r_incscore, r_declives, r_stats_reset;
  logic       r_freeze, r_over;
  logic       w_tick, w_start, w_hit, w_miss;
  logic       w_inc, w_dec, w_srst;
  logic [9:0] w_cnt_next;

  assign w_tick  = vsync       & ~r_vsync_q;
  assign w_start = start_btn   & ~r_start_q;
  assign w_hit   = brick_hit   & ~r_hit_q;
  assign w_miss  = ball_missed & ~r_miss_q;

  // Frame count this tick would reach; timed phases expire when it hits N.
  assign w_cnt_next = r_cnt + 10'd1;

  always_comb begin
    w_next = r_state;
    w_inc  = 1'b0;
    w_dec  = 1'b0;
    w_srst = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_srst = 1'b1;
          w_next = ST_SERVE;
        end
`ifdef ATTRACT_MODE_EN
        else if (w_tick && (w_cnt_next == ATTRACT_FRAMES[9:0])) begin
          w_next = ST_ATTRACT;
        end
`endif
      end
      ST_SERVE: begin
        if (w_tick && (w_cnt_next == c_serve_frames)) w_next = ST_PLAY;
      end
      ST_PLAY: begin
        w_inc = w_hit;
        if (w_miss) begin
          w_dec  = 1'b1;
          w_next = ST_LOST;
        end
      end
      ST_LOST: begin
        // lives_in has settled long before expiry, so sample it only here.
        if (w_tick && (w_cnt_next == c_lost_frames))
          w_next = (lives_in == 4'd0) ? ST_OVER : ST_SERVE;
      end
      ST_OVER: begin
        if (w_start) begin
          w_srst = 1'b1;
          w_next = ST_SERVE;
        end
      end
`ifdef ATTRACT_MODE_EN
      ST_ATTRACT: begin
        // Collision edges are still tracked but never score in demo play.
        if (w_start) begin
          w_srst = 1'b1;
          w_next = ST_SERVE;
        end
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_vsync_q     <= 1'b0;
      r_start_q     <= 1'b0;
      r_hit_q       <= 1'b0;
      r_miss_q      <= 1'b0;
      r_incscore    <= 1'b0;
      r_declives    <= 1'b0;
      r_stats_reset <= 1'b0;
      r_freeze      <= 1'b1;
      r_over        <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_vsync_q     <= vsync;
      r_start_q     <= start_btn;
      r_hit_q       <= brick_hit;
      r_miss_q      <= ball_missed;
      r_incscore    <= w_inc;
      r_declives    <= w_dec;
      r_stats_reset <= w_srst;
      // Counter restarts on every state entry so each phase times from zero.
      if (w_next != r_state) r_cnt <= '0;
      else if (w_tick)       r_cnt <= w_cnt_next;
      r_freeze      <= ~((w_next == ST_PLAY) || (w_next == ST_ATTRACT));
      r_over        <= (w_next == ST_OVER);
    end
  end

`ifdef ATTRACT_MODE_EN
  logic r_demo;
  always_ff @(posedge clk) begin
    if (reset) r_demo <= 1'b0;
    else       r_demo <= (w_next == ST_ATTRACT);
  end
  assign demo = r_demo;
`else
  logic w_unused_attract;
  assign w_unused_attract = ^ATTRACT_FRAMES[9:0];
  assign demo = 1'b0;
`endif

  assign incscore    = r_incscore;
  assign declives    = r_declives;
  assign stats_reset = r_stats_reset;
  assign ball_freeze = r_freeze;
  assign game_over   = r_over;
  assign state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
//==============================================================================
// Module   : tb_game_flow_ctrl
// Purpose  : Self-checking bench for game_flow_ctrl. A phase/countdown model
//            predicts outputs per cycle; expectations are queued and a
//            monitor compares them against the DUT at the falling edge.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_game_flow_ctrl;

  localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_LOST = 3, P_OVER = 4, P_ATTRACT = 5;
  localparam int N_SERVE = 60, N_LOST = 90, N_ATTRACT = 300;
`ifdef ATTRACT_MODE_EN
  localparam bit ATTR_EN = 1'b1;
`else
  localparam bit ATTR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0, start_btn = 1'b0, brick_hit = 1'b0, ball_missed = 1'b0;
  logic [3:0] lives_in = 4'd3;
  logic       incscore, declives, stats_reset, ball_freeze, game_over, demo;
  logic [2:0] state;

  game_flow_ctrl #(.SERVE_FRAMES(N_SERVE), .LOST_FRAMES(N_LOST), .ATTRACT_FRAMES(N_ATTRACT)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .start_btn(start_btn),
    .brick_hit(brick_hit), .ball_missed(ball_missed), .lives_in(lives_in),
    .incscore(incscore), .declives(declives), .stats_reset(stats_reset),
    .ball_freeze(ball_freeze), .game_over(game_over), .demo(demo), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct { int cyc; logic [2:0] st; logic fr; logic go; logic dm; } st_exp_t;
  typedef struct { int cyc; logic inc; logic dec; logic sr; } sb_exp_t;
  st_exp_t st_q[$];
  sb_exp_t sb_q[$];

  int errors = 0, checks = 0;
  int d_inc = 0, d_dec = 0, d_sr = 0;   // strobes seen from DUT
  int m_inc = 0, m_dec = 0, m_sr = 0;   // strobes predicted by model

  // Model: current phase, frames left before a timed phase expires, last inputs.
  int m_phase = P_IDLE;
  int m_left  = N_ATTRACT;
  bit p_vs = 0, p_st = 0, p_hit = 0, p_miss = 0;
  int vs_ctr = 0;

  function automatic void enter(input int ph);
    m_phase = ph;
    case (ph)
      P_SERVE: m_left = N_SERVE;
      P_LOST:  m_left = N_LOST;
      P_IDLE:  m_left = N_ATTRACT;
      default: m_left = 0;
    endcase
  endfunction

  // Apply current inputs for the coming edge, predict, then advance one clock.
  task automatic step();
    bit e_st, e_hit, e_miss, tick, inc, dec, sr;
    int nxt;
    st_exp_t se;
    sb_exp_t be;
    vsync = ((vs_ctr % 8) < 4);
    vs_ctr++;
    inc = 0; dec = 0; sr = 0; nxt = -1;
    if (reset) begin
      enter(P_IDLE);
      p_vs = 0; p_st = 0; p_hit = 0; p_miss = 0;
    end else begin
      tick   = vsync && !p_vs;
      e_st   = start_btn && !p_st;
      e_hit  = brick_hit && !p_hit;
      e_miss = ball_missed && !p_miss;
      case (m_phase)
        P_IDLE: begin
          if (e_st) begin sr = 1; nxt = P_SERVE; end
          else if (ATTR_EN && tick) begin
            m_left--;
            if (m_left == 0) nxt = P_ATTRACT;
          end
        end
        P_SERVE: if (tick) begin m_left--; if (m_left == 0) nxt = P_PLAY; end
        P_PLAY: begin
          inc = e_hit;
          if (e_miss) begin dec = 1; nxt = P_LOST; end
        end
        P_LOST: if (tick) begin
          m_left--;
          if (m_left == 0) nxt = (lives_in == 0) ? P_OVER : P_SERVE;
        end
        P_OVER, P_ATTRACT: if (e_st) begin sr = 1; nxt = P_SERVE; end
        default: nxt = P_IDLE;
      endcase
      if (nxt >= 0) enter(nxt);
      p_vs = vsync; p_st = start_btn; p_hit = brick_hit; p_miss = ball_missed;
    end
    se.cyc = cyc + 1;
    se.st  = 3'(m_phase);
    se.fr  = !(m_phase == P_PLAY || m_phase == P_ATTRACT);
    se.go  = (m_phase == P_OVER);
    se.dm  = (m_phase == P_ATTRACT);
    st_q.push_back(se);
    if (inc || dec || sr) begin
      be.cyc = cyc + 1; be.inc = inc; be.dec = dec; be.sr = sr;
      sb_q.push_back(be);
      m_inc += int'(inc); m_dec += int'(dec); m_sr += int'(sr);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int ph, input int budget, input string name);
    int n = 0;
    while (m_phase != ph && n < budget) begin step(); n++; end
    checks++;
    if (m_phase != ph) begin
      errors++;
      $display("FAIL %s: timeout, model phase %0d required %0d", name, m_phase, ph);
    end
  endtask

  task automatic check_cnt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare state-derived outputs every cycle, strobes when presented.
  always @(negedge clk) begin
    st_exp_t se;
    sb_exp_t be;
    while (st_q.size() > 0 && st_q[0].cyc < cyc) void'(st_q.pop_front());
    if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
      se = st_q.pop_front();
      checks++;
      if ({state, ball_freeze, game_over, demo} !== {se.st, se.fr, se.go, se.dm}) begin
        errors++;
        $display("FAIL outputs cyc %0d: state=%0d fr=%b go=%b demo=%b expected state=%0d fr=%b go=%b demo=%b",
                 cyc, state, ball_freeze, game_over, demo, se.st, se.fr, se.go, se.dm);
      end
    end
    if (incscore === 1'b1 || declives === 1'b1 || stats_reset === 1'b1) begin
      d_inc += int'(incscore === 1'b1);
      d_dec += int'(declives === 1'b1);
      d_sr  += int'(stats_reset === 1'b1);
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL strobe cyc %0d: unexpected inc=%b dec=%b sr=%b, expected none",
                 cyc, incscore, declives, stats_reset);
      end else begin
        be = sb_q.pop_front();
        if (be.cyc != cyc || {incscore, declives, stats_reset} !== {be.inc, be.dec, be.sr}) begin
          errors++;
          $display("FAIL strobe cyc %0d: inc=%b dec=%b sr=%b expected inc=%b dec=%b sr=%b at cyc %0d",
                   cyc, incscore, declives, stats_reset, be.inc, be.dec, be.sr, be.cyc);
        end
      end
    end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      be = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL strobe cyc %0d: missing strobe, expected inc=%b dec=%b sr=%b", cyc, be.inc, be.dec, be.sr);
    end
  end

  initial begin
    int b_inc, b_dec, b_sr;
    #1;
    reset = 1'b1;
    steps(3);
    reset = 1'b0;
    steps(2);

    // Start held 5 cycles -> exactly one stats_reset, then serve runs 60 frames.
    b_sr = d_sr;
    start_btn = 1'b1; steps(5); start_btn = 1'b0;
    steps(2);
    check_cnt("start_single_srst", d_sr - b_sr, 1);
    run_until(P_PLAY, 1000, "serve_to_play");
    steps(2);

    // Four 3-cycle brick_hit levels -> four incscore pulses, no declives.
    b_inc = d_inc; b_dec = d_dec;
    for (int k = 0; k < 4; k++) begin
      brick_hit = 1'b1; steps(3);
      brick_hit = 1'b0; steps(2);
    end
    steps(2);
    check_cnt("hits_inc_count", d_inc - b_inc, 4);
    check_cnt("hits_no_dec", d_dec - b_dec, 0);

    // Miss with lives left -> LOST then SERVE.
    lives_in = 4'd2;
    b_dec = d_dec;
    ball_missed = 1'b1; step(); ball_missed = 1'b0;
    steps(2);
    check_cnt("miss_dec_count", d_dec - b_dec, 1);
    run_until(P_SERVE, 1500, "lost_to_serve");
    run_until(P_PLAY, 1000, "serve_to_play2");

    // Miss with no lives -> OVER, then start restarts the game.
    lives_in = 4'd0;
    ball_missed = 1'b1; step(); ball_missed = 1'b0;
    run_until(P_OVER, 1500, "lost_to_over");
    steps(4);
    b_sr = d_sr;
    start_btn = 1'b1; steps(2); start_btn = 1'b0;
    steps(2);
    check_cnt("over_restart_srst", d_sr - b_sr, 1);
    run_until(P_PLAY, 1000, "serve_to_play3");

    // Simultaneous hit and miss, then reset in LOST.
    lives_in = 4'd3;
    b_inc = d_inc; b_dec = d_dec;
    brick_hit = 1'b1; ball_missed = 1'b1; step();
    brick_hit = 1'b0; ball_missed = 1'b0; steps(10);
    check_cnt("both_inc", d_inc - b_inc, 1);
    check_cnt("both_dec", d_dec - b_dec, 1);
    reset = 1'b1; step(); reset = 1'b0;
    steps(3);

`ifdef ATTRACT_MODE_EN
    run_until(P_ATTRACT, 3000, "idle_to_attract");
    b_inc = d_inc;
    for (int k = 0; k < 3; k++) begin
      brick_hit = 1'b1; steps(2); brick_hit = 1'b0; steps(2);
    end
    check_cnt("attract_no_inc", d_inc - b_inc, 0);
    start_btn = 1'b1; step(); start_btn = 1'b0;
    run_until(P_SERVE, 10, "attract_to_serve");
    steps(2);
`endif

    // Randomized play.
    for (int i = 0; i < 20000; i++) begin
      reset = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 149) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 5) == 0)   brick_hit = ~brick_hit;
      if ($urandom_range(0, 99) == 0)  ball_missed = ~ball_missed;
      if ($urandom_range(0, 199) == 0) lives_in = 4'($urandom_range(0, 3));
      step();
    end
    reset = 1'b0; start_btn = 1'b0; brick_hit = 1'b0; ball_missed = 1'b0;
    steps(4);

    check_cnt("total_inc", d_inc, m_inc);
    check_cnt("total_dec", d_dec, m_dec);
    check_cnt("total_srst", d_sr, m_sr);
    check_cnt("strobe_queue_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
